// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory-bus arbiter: FSM states, owner tags
// and the request-field bundle that travels on the shared bus.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        TAG_INST = 1'b0,
        TAG_DATA = 1'b1
    } owner_tag_t;

    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_IDLE = '0;

    // Fetches are always word-sized reads with no write data.
    function automatic bus_req_t inst_fetch_req(input logic [31:0] addr);
        bus_req_t req;
        req.wr    = 1'b0;
        req.size  = SIZE_WORD;
        req.addr  = addr;
        req.wdata = 32'd0;
        return req;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO: remembers which master each accepted bus request
// belongs to so responses can be routed back in acceptance order.
module arb_tag_fifo
    import mem_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_push,
    input  owner_tag_t                    i_push_tag,
    input  logic                          i_pop,
    output owner_tag_t                    o_head,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    owner_tag_t    r_mem [FIFO_DEPTH];

    logic w_do_pop;
    logic w_do_push;

    // A pop frees a slot in the same cycle, so push-when-full is legal then.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_push_tag;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch master and a load/store master onto one
// pipelined memory bus. Define ARB_ROUND_ROBIN_EN for round-robin grants;
// otherwise data has fixed priority over inst.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          inst_req,
    input  logic [31:0]                   inst_addr,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [31:0]                   inst_rdata,
    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [1:0]                    data_size,
    input  logic [31:0]                   data_addr,
    input  logic [31:0]                   data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [31:0]                   data_rdata,
    output logic                          m_req,
    output logic                          m_wr,
    output logic [1:0]                    m_size,
    output logic [31:0]                   m_addr,
    output logic [31:0]                   m_wdata,
    input  logic                          m_addr_ok,
    input  logic                          m_data_ok,
    input  logic [31:0]                   m_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    bus_req_t    r_latched;
    bus_req_t    w_latched_next;

    bus_req_t    w_inst_fields;
    bus_req_t    w_data_fields;
    bus_req_t    w_fields;
    owner_tag_t  w_owner;
    owner_tag_t  w_head;
    logic        w_m_req;
    logic        w_pick_data;
    logic        w_full;
    logic        w_accept;
    logic        w_pop;
    logic [CW-1:0] w_count;

    assign w_inst_fields = inst_fetch_req(inst_addr);
    assign w_data_fields = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign w_full        = (w_count == CW'(FIFO_DEPTH));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_data;

    // After every accepted request the other master gets the next tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr_data <= 1'b1;
        end else if (w_accept) begin
            r_rr_data <= (w_owner == TAG_INST);
        end
    end

    assign w_pick_data = data_req && (!inst_req || r_rr_data);
`else
    assign w_pick_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_latched <= BUS_REQ_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_latched <= w_latched_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_latched_next = r_latched;
        w_m_req        = 1'b0;
        w_owner        = TAG_INST;
        w_fields       = BUS_REQ_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (!w_full && (inst_req || data_req)) begin
                    w_m_req  = 1'b1;
                    w_owner  = w_pick_data ? TAG_DATA : TAG_INST;
                    w_fields = w_pick_data ? w_data_fields : w_inst_fields;
                    // Bus stalled: freeze the grant so the master may move on.
                    if (!m_addr_ok) begin
                        w_latched_next = w_fields;
                        w_state_next   = w_pick_data ? ST_HOLD_D : ST_HOLD_I;
                    end
                end
            end
            ST_HOLD_I: begin
                w_m_req  = 1'b1;
                w_owner  = TAG_INST;
                w_fields = r_latched;
                if (m_addr_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD_D: begin
                w_m_req  = 1'b1;
                w_owner  = TAG_DATA;
                w_fields = r_latched;
                if (m_addr_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (!resetn) begin
            w_m_req = 1'b0;
        end
    end

    assign w_accept = w_m_req && m_addr_ok;
    assign w_pop    = resetn && m_data_ok && (w_count != '0);

    arb_tag_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_accept),
        .i_push_tag (w_owner),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign m_req        = w_m_req;
    assign m_wr         = w_fields.wr;
    assign m_size       = w_fields.size;
    assign m_addr       = w_fields.addr;
    assign m_wdata      = w_fields.wdata;

    assign inst_addr_ok = w_accept && (w_owner == TAG_INST);
    assign data_addr_ok = w_accept && (w_owner == TAG_DATA);
    assign inst_data_ok = w_pop && (w_head == TAG_INST);
    assign data_data_ok = w_pop && (w_head == TAG_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign outstanding  = w_count;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a high-level model of the
// two masters and the bus slave predicts grants, responses and the count.
module tb_mem_bus_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic [$clog2(DEPTH):0] outstanding;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outstanding(outstanding)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fld_t;

    typedef struct {
        bit          owner;   // 0 = inst, 1 = data
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];    // scoreboard: responses the monitor expects, in order
    resp_t pend_q[$];   // slave view: accepted requests not yet answered

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Model state
    bit   held, held_owner, rr_data;
    fld_t held_f;
    bit   i_busy, d_busy;
    fld_t i_f, d_f;
    bit   acc, hold_next, cyc_owner, resp_real;
    fld_t cyc_f;
    int   p_aok, p_dok, p_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic fld_t inst_fields(input logic [31:0] a);
        fld_t f;
        f.wr = 1'b0; f.size = 2'd2; f.addr = a; f.wdata = 32'd0;
        return f;
    endfunction

    // Predict the bus request for this cycle from the arbitration rules.
    task automatic eval_bus();
        bit   exp_req;
        bit   own;
        fld_t f;
        exp_req = 0; own = 0; f = '0;
        if (!resetn) begin
            exp_req = 0;
        end else if (held) begin
            exp_req = 1; own = held_owner; f = held_f;
        end else if (pend_q.size() < DEPTH && (i_busy || d_busy)) begin
            exp_req = 1;
`ifdef ARB_ROUND_ROBIN_EN
            own = d_busy && (!i_busy || rr_data);
`else
            own = d_busy;
`endif
            f = own ? d_f : inst_fields(i_f.addr);
        end
        check("m_req", 64'(m_req), 64'(exp_req));
        if (exp_req) begin
            check("m_addr", 64'(m_addr), 64'(f.addr));
            check("m_wdata", 64'(m_wdata), 64'(f.wdata));
            check("m_wr_size", 64'({m_wr, m_size}), 64'({f.wr, f.size}));
        end
        check("inst_addr_ok", 64'(inst_addr_ok), 64'(exp_req && !own && m_addr_ok));
        check("data_addr_ok", 64'(data_addr_ok), 64'(exp_req && own && m_addr_ok));
        acc       = exp_req && m_addr_ok;
        hold_next = exp_req && !m_addr_ok;
        cyc_owner = own;
        cyc_f     = f;
    endtask

    // Apply what happened at the clock edge to the model.
    task automatic commit();
        resp_t r;
        if (!resetn) begin
            exp_q.delete();
            pend_q.delete();
            held = 0;
            rr_data = 1;
        end else begin
            if (resp_real) void'(pend_q.pop_front());
            if (acc) begin
                r.owner = cyc_owner;
                r.rdata = $urandom;
                pend_q.push_back(r);
                exp_q.push_back(r);
                if (cyc_owner) d_busy = 0; else i_busy = 0;
                rr_data = !cyc_owner;
                held = 0;
            end else if (hold_next) begin
                held = 1; held_owner = cyc_owner; held_f = cyc_f;
            end
        end
    endtask

    task automatic stimulus();
        if (!i_busy && $urandom_range(99) < p_req) begin
            i_busy = 1;
            i_f = inst_fields($urandom & 32'hFFFF_FFFC);
        end
        if (!d_busy && $urandom_range(99) < p_req) begin
            d_busy = 1;
            d_f.wr = 1'($urandom);
            d_f.size = 2'($urandom_range(2));
            d_f.addr = $urandom;
            d_f.wdata = $urandom;
        end
        // A held master may wander; the bus must keep the latched fields.
        if (held && $urandom_range(99) < 40) begin
            if (held_owner) begin
                d_f.addr = $urandom; d_f.wdata = $urandom; d_f.wr = 1'($urandom);
            end else begin
                i_f.addr = $urandom;
            end
        end
        inst_req   = i_busy;
        inst_addr  = i_f.addr;
        data_req   = d_busy;
        data_wr    = d_f.wr;
        data_size  = d_f.size;
        data_addr  = d_f.addr;
        data_wdata = d_f.wdata;
        m_addr_ok  = ($urandom_range(99) < p_aok);
        m_data_ok  = ($urandom_range(99) < p_dok);
        resp_real  = m_data_ok && resetn && (pend_q.size() > 0);
        m_rdata    = resp_real ? pend_q[0].rdata : $urandom;
    endtask

    // Monitor: checks the count and pops the scoreboard on each response.
    initial begin
        resp_t r;
        wait (started);
        forever begin
            @(negedge clk);
            check("outstanding", 64'(outstanding), 64'(exp_q.size()));
            if (resetn && m_data_ok && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("inst_data_ok", 64'(inst_data_ok), 64'(!r.owner));
                check("data_data_ok", 64'(data_data_ok), 64'(r.owner));
                check("inst_rdata", 64'(inst_rdata), 64'(r.rdata));
                check("data_rdata", 64'(data_rdata), 64'(r.rdata));
            end else begin
                check("idle_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
            end
        end
    end

    int p_aok_t[4] = '{100, 85, 35, 60};
    int p_dok_t[4] = '{40, 10, 70, 45};
    int p_req_t[4] = '{100, 90, 60, 70};

    initial begin
        resetn = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        held = 0; rr_data = 1; i_busy = 0; d_busy = 0; i_f = '0; d_f = '0;
        acc = 0; hold_next = 0; resp_real = 0;
        p_aok = 0; p_dok = 0; p_req = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1;
        started = 1;
        for (int ph = 0; ph < 4; ph++) begin
            p_aok = p_aok_t[ph];
            p_dok = p_dok_t[ph];
            p_req = p_req_t[ph];
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                eval_bus();
                @(posedge clk);
                #1;
                commit();
                // Mid-traffic reset pulse with live requests and responses.
                resetn = !(ph == 3 && cyc >= 200 && cyc < 203);
                stimulus();
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
